// File: rtl/mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_fifo_ctrl
// Purpose  : Sequencer that turns a single-port DEPTH x DW memory array into
//            a first-in/first-out buffer. One memory access per cycle; a
//            producer write and an output-register prefetch compete for the
//            port and are arbitrated round-robin.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            push_valid/ready  - producer handshake, push_data sampled on accept
//            pop_valid/ready   - consumer handshake, pop_data is registered
//            count             - memory occupancy plus the output register
//            mem_wen/addr/wdata- memory shared port, mem_rdata combinational
// Revision : 1.0 - initial release
// ============================================================================
module mem_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [DW-1:0] pop_data,
    output logic [AW:0]   count,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [0:0]  c_OP_WRITE   = 1'b0;
    localparam logic [0:0]  c_OP_READ    = 1'b1;
    localparam logic [AW:0] c_FULL_CNT   = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_mem_cnt;
    logic [0:0]    r_last_op;
    logic          r_pop_valid;
    logic [DW-1:0] r_pop_data;

    logic          w_wr_possible;
    logic          w_pf_wanted;
    logic          w_grant_write;
    logic          w_push_acc;
    logic          w_read_do;

    // Arbitration. The write grant is decided without looking at push_valid
    // so that push_ready never depends on it. If the write slot is granted
    // but the producer has nothing to offer, the idle port is handed to the
    // prefetch instead of being wasted; otherwise a pending prefetch could
    // starve forever while the producer stays idle.
    always_comb begin
        w_wr_possible = (r_mem_cnt != c_FULL_CNT);
        w_pf_wanted   = (r_mem_cnt != '0) && (!r_pop_valid || pop_ready);
        w_grant_write = 1'b0;
        if (w_wr_possible && w_pf_wanted) begin
            w_grant_write = (r_last_op == c_OP_READ);
        end else begin
            w_grant_write = w_wr_possible;
        end
        w_push_acc = push_valid && w_grant_write;
        w_read_do  = w_pf_wanted && !w_push_acc;
    end

    assign push_ready = w_grant_write;
    assign mem_wen    = w_push_acc;
    assign mem_addr   = w_push_acc ? r_wr_ptr : r_rd_ptr;
    assign mem_wdata  = push_data;
    assign pop_valid  = r_pop_valid;
    assign pop_data   = r_pop_data;
    assign count      = r_mem_cnt + {{AW{1'b0}}, r_pop_valid};

    // Pointers wrap by natural overflow; occupancy is tracked only by
    // r_mem_cnt, never derived from the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_last_op   <= c_OP_READ;
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_mem_cnt <= r_mem_cnt + (AW+1)'(1);
                r_last_op <= c_OP_WRITE;
            end else if (w_read_do) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_mem_cnt   <= r_mem_cnt - (AW+1)'(1);
                r_last_op   <= c_OP_READ;
                r_pop_data  <= mem_rdata;
                r_pop_valid <= 1'b1;
            end
            // A pop without a refill empties the output register; the data
            // value itself is left untouched.
            if (r_pop_valid && pop_ready && !w_read_do) begin
                r_pop_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
